// File: rtl/dna_seq_loader_if.sv
// Loader-facing bundle: load request, base stream, SRAM write port and generator handshake.
// master is the loader side; slave is the environment driving bases and consuming writes.
interface dna_seq_loader_if #(
    parameter int unsigned BASE_W = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = 9
);
    logic              load_start;
    logic [LEN_W-1:0]  seq_len;
    logic [BASE_W-1:0] base_in;
    logic              base_valid;
    logic              base_ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic              sram_csb;
    logic              sram_web;
    logic              sram_oeb;
    logic              start_gen;
    logic              gen_done;
    logic              busy;
    logic              load_done;

    modport master (
        input  load_start, seq_len, base_in, base_valid, gen_done,
        output base_ready, sram_addr, sram_din, sram_csb, sram_web, sram_oeb,
               start_gen, busy, load_done
    );

    modport slave (
        output load_start, seq_len, base_in, base_valid, gen_done,
        input  base_ready, sram_addr, sram_din, sram_csb, sram_web, sram_oeb,
               start_gen, busy, load_done
    );
endinterface

// File: rtl/dna_seq_loader.sv
// Packs a stream of 2-bit DNA bases into SRAM words, then kicks off hash generation
// and stays busy until the generator reports done.
module dna_seq_loader #(
    parameter int unsigned BASE_W     = 2,
    parameter int unsigned WORD_BASES = 16,
    parameter int unsigned DATA_W     = BASE_W * WORD_BASES,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_WORDS  = 16,
    parameter int unsigned LEN_W      = 9
) (
    input logic               clk,
    input logic               reset,
    dna_seq_loader_if.master  bus
);
    localparam int unsigned SLOT_W = $clog2(WORD_BASES);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(NUM_WORDS * WORD_BASES);
    localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(WORD_BASES - 1);

    typedef enum logic [2:0] {StIdle, StFill, StWrite, StKick, StWaitGen} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  base_cnt_q, base_cnt_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [DATA_W-1:0] pack_q, pack_d;
    logic              load_done_q, load_done_d;
    logic [SLOT_W-1:0] slot;

    assign slot = base_cnt_q[SLOT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            base_cnt_q  <= '0;
            word_idx_q  <= '0;
            pack_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            base_cnt_q  <= base_cnt_d;
            word_idx_q  <= word_idx_d;
            pack_q      <= pack_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        base_cnt_d  = base_cnt_q;
        word_idx_d  = word_idx_q;
        pack_d      = pack_q;
        load_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.load_start) begin
                    len_d      = (bus.seq_len > MaxLen) ? MaxLen : bus.seq_len;
                    base_cnt_d = '0;
                    word_idx_d = '0;
                    pack_d     = '0;
                    // An empty read completes immediately without touching SRAM
                    if (len_d == '0) load_done_d = 1'b1;
                    else             state_d     = StFill;
                end
            end
            StFill: begin
                if (bus.base_valid) begin
                    pack_d[slot*BASE_W +: BASE_W] = bus.base_in;
                    base_cnt_d = base_cnt_q + 1'b1;
                    if (slot == LastSlot || base_cnt_d == len_q) state_d = StWrite;
                end
            end
            StWrite: begin
                pack_d     = '0;
                // Wraps only after the final word, when it is never used again
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (base_cnt_q == len_q) ? StKick : StFill;
            end
            StKick: state_d = StWaitGen;
            StWaitGen: begin
                if (bus.gen_done) begin
                    state_d     = StIdle;
                    load_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.base_ready = (state_q == StFill);
        bus.sram_csb   = (state_q != StWrite);
        bus.sram_web   = (state_q != StWrite);
        bus.sram_oeb   = 1'b1;
        bus.sram_addr  = (state_q == StWrite) ? word_idx_q : '0;
        bus.sram_din   = (state_q == StWrite) ? pack_q : '0;
        bus.start_gen  = (state_q == StKick);
        bus.busy       = (state_q != StIdle);
        bus.load_done  = load_done_q;
    end
endmodule

// File: tb/tb_dna_seq_loader.sv
// Directed + randomized bench for dna_seq_loader; expected SRAM image is computed
// from the base list with plain arithmetic.
module tb_dna_seq_loader;
    logic clk;
    logic reset;

    dna_seq_loader_if bus ();

    dna_seq_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Monitor state (written only by the monitor)
    logic [3:0]  wr_addr_q [$];
    logic [31:0] wr_din_q  [$];
    int cyc = 0, hs_cnt = 0, sg_cnt = 0, last_hs_cyc = 0, sg_cyc = 0;
    int busy_drop_cnt = 0, rdy_in_write_cnt = 0;
    bit in_load = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (!bus.sram_csb && !bus.sram_web) begin
                wr_addr_q.push_back(bus.sram_addr);
                wr_din_q.push_back(bus.sram_din);
                if (bus.base_ready) rdy_in_write_cnt <= rdy_in_write_cnt + 1;
            end
            if (bus.base_valid && bus.base_ready) begin
                hs_cnt      <= hs_cnt + 1;
                last_hs_cyc <= cyc;
            end
            if (bus.start_gen) begin
                sg_cnt <= sg_cnt + 1;
                sg_cyc <= cyc;
            end
            if (in_load && !bus.busy) busy_drop_cnt <= busy_drop_cnt + 1;
        end
    end

    logic [1:0]  bases [300];
    logic [31:0] exp_w [16];
    int wr_base, hs_base, sg_base, bd_base, rw_base;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        wr_base = wr_addr_q.size();
        hs_base = hs_cnt;
        sg_base = sg_cnt;
        bd_base = busy_drop_cnt;
        rw_base = rdy_in_write_cnt;
    endtask

    // vmode: 0 valid always, 1 valid every third cycle, 2 random valid
    task automatic do_load(input int req_len, input int vmode);
        int eff, idx;
        bit v, hs;
        eff = (req_len > 256) ? 256 : req_len;
        snap();
        bus.seq_len    = 9'(req_len);
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        in_load = 1'b1;
        idx = 0;
        for (int k = 0; k < 4000 && idx < eff; k++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (k % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.base_valid = v;
            bus.base_in    = bases[idx];
            hs = v && bus.base_ready;
            step();
            if (hs) idx++;
        end
        bus.base_valid = 1'b0;
        chk("feed_complete", idx, eff);
        for (int k = 0; k < 20 && sg_cnt == sg_base; k++) step();
    endtask

    task automatic check_load(input string tag, input int req_len);
        int n, n_words, got;
        n = (req_len > 256) ? 256 : req_len;
        for (int w = 0; w < 16; w++) exp_w[w] = '0;
        for (int i = 0; i < n; i++) exp_w[i / 16][2 * (i % 16) +: 2] = bases[i];
        n_words = (n + 15) / 16;
        got = wr_addr_q.size() - wr_base;
        chk({tag, "_nwrites"}, got, n_words);
        for (int i = 0; i < got && i < n_words; i++) begin
            chk({tag, "_addr"}, wr_addr_q[wr_base + i], i);
            chk({tag, "_din"}, wr_din_q[wr_base + i], exp_w[i]);
        end
        chk({tag, "_handshakes"}, hs_cnt - hs_base, n);
        chk({tag, "_start_gen_cnt"}, sg_cnt - sg_base, 1);
        chk({tag, "_start_gen_lat"}, sg_cyc - last_hs_cyc, 2);
        chk({tag, "_busy_held"}, busy_drop_cnt - bd_base, 0);
        chk({tag, "_ready_in_write"}, rdy_in_write_cnt - rw_base, 0);
    endtask

    task automatic finish_gen(input string tag, input int hold);
        int w0;
        w0 = wr_addr_q.size();
        for (int k = 0; k < hold; k++) begin
            if (k == 10) begin
                bus.seq_len    = 9'd16;
                bus.load_start = 1'b1;
            end
            step();
            bus.load_start = 1'b0;
        end
        chk({tag, "_busy_wait"}, bus.busy, 1'b1);
        bus.gen_done = 1'b1;
        step();
        bus.gen_done = 1'b0;
        in_load = 1'b0;
        chk({tag, "_load_done"}, bus.load_done, 1'b1);
        chk({tag, "_busy_idle"}, bus.busy, 1'b0);
        step();
        chk({tag, "_load_done_pulse"}, bus.load_done, 1'b0);
        chk({tag, "_no_writes_while_waiting"}, wr_addr_q.size() - w0, 0);
    endtask

    initial begin
        int idx, r_len;
        reset = 1'b1;
        bus.load_start = 1'b0;
        bus.seq_len    = '0;
        bus.base_in    = '0;
        bus.base_valid = 1'b0;
        bus.gen_done   = 1'b0;
        step();
        step();
        chk("rst_outputs", {bus.base_ready, bus.sram_csb, bus.sram_web, bus.sram_oeb,
                            bus.start_gen, bus.busy, bus.load_done}, 7'b0111000);
        chk("rst_addr_din", {bus.sram_addr, bus.sram_din}, 36'h0);
        reset = 1'b0;
        step();

        // 1: 0,1,2,3 repeated, valid held high
        for (int i = 0; i < 300; i++) bases[i] = 2'(i % 4);
        do_load(16, 0);
        check_load("s1", 16);
        chk("s1_known_word", exp_w[0], 32'hE4E4E4E4);
        finish_gen("s1", 3);

        // 2: twenty T bases, partial last word
        for (int i = 0; i < 300; i++) bases[i] = 2'd3;
        do_load(20, 0);
        check_load("s2", 20);
        finish_gen("s2", 2);

        // 3: sparse valid
        for (int i = 0; i < 300; i++) bases[i] = 2'(i % 4);
        do_load(16, 1);
        check_load("s3", 16);
        finish_gen("s3", 2);

        // 4: over-length request clamps to 256
        for (int i = 0; i < 300; i++) bases[i] = 2'($urandom_range(0, 3));
        do_load(300, 0);
        check_load("s4", 300);
        bus.base_valid = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("s4_ready_low", bus.base_ready, 1'b0);
        chk("s4_no_extra_hs", hs_cnt - hs_base, 256);
        bus.base_valid = 1'b0;
        finish_gen("s4", 2);

        // 5: reset after 7 accepted bases
        snap();
        bus.seq_len    = 9'd16;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        idx = 0;
        for (int k = 0; k < 50 && idx < 7; k++) begin
            bus.base_valid = 1'b1;
            bus.base_in    = bases[idx];
            step();
            idx++;
        end
        bus.base_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("s5_rst_outputs", {bus.base_ready, bus.sram_csb, bus.sram_web, bus.sram_oeb,
                               bus.start_gen, bus.busy, bus.load_done}, 7'b0111000);
        chk("s5_rst_addr_din", {bus.sram_addr, bus.sram_din}, 36'h0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("s5_no_write", wr_addr_q.size() - wr_base, 0);
        chk("s5_no_start", sg_cnt - sg_base, 0);
        for (int i = 0; i < 300; i++) bases[i] = 2'(i % 4);
        do_load(16, 0);
        check_load("s5", 16);

        // 6: long wait with ignored load_start
        finish_gen("s6", 50);

        // 6b: zero-length request
        snap();
        bus.seq_len    = 9'd0;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        chk("s6_len0_done", bus.load_done, 1'b1);
        chk("s6_len0_busy", bus.busy, 1'b0);
        step();
        chk("s6_len0_pulse", bus.load_done, 1'b0);
        for (int k = 0; k < 5; k++) step();
        chk("s6_len0_no_write", wr_addr_q.size() - wr_base, 0);
        chk("s6_len0_no_start", sg_cnt - sg_base, 0);

        // Random lengths, bases and valid gaps
        for (int t = 0; t < 4; t++) begin
            r_len = $urandom_range(1, 255);
            for (int i = 0; i < 300; i++) bases[i] = 2'($urandom_range(0, 3));
            do_load(r_len, 2);
            check_load("rnd", r_len);
            finish_gen("rnd", $urandom_range(1, 6));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
